// File: rtl/bit_stream_serializer_if.sv
// Parallel-in / serial-out bus bundle for bit_stream_serializer.
// The serializer is the slave; the word source and bit consumer sit on the master side.
interface bit_stream_serializer_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
);
    localparam int unsigned LW = $clog2(DEPTH) + 1;

    logic             flush;
    logic [WIDTH-1:0] din;
    logic             din_valid;
    logic             din_ready;
    logic             bit_out;
    logic             bit_valid;
    logic             busy;
    logic [LW-1:0]    level;

    modport master (
        output flush, din, din_valid,
        input  din_ready, bit_out, bit_valid, busy, level
    );

    modport slave (
        input  flush, din, din_valid,
        output din_ready, bit_out, bit_valid, busy, level
    );
endinterface

// File: rtl/bit_stream_serializer.sv
// Buffers parallel words in a small FIFO and streams them out one bit per clock,
// back-to-back with no gap cycles between consecutive words.
module bit_stream_serializer #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned DEPTH     = 4,
    parameter bit          MSB_FIRST = 1'b1,
    parameter bit          IDLE_BIT  = 1'b0
) (
    input logic                    clk,
    input logic                    reset,
    bit_stream_serializer_if.slave bus
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned LW = $clog2(DEPTH) + 1;
    localparam int unsigned CW = $clog2(WIDTH);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [LW-1:0]    level_q, level_d;
    logic [WIDTH-1:0] word_q, word_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             bit_q, bit_d;
    logic             push, pop;
    logic             have_word, last_bit;
    logic [WIDTH-1:0] head;
    logic [CW-1:0]    cnt_nxt;

    // Bit i of a word in transmit order.
    function automatic logic bit_at(input logic [WIDTH-1:0] w, input logic [CW-1:0] i);
        if (MSB_FIRST)
            return w[CW'(WIDTH - 1) - i];
        else
            return w[i];
    endfunction

    assign have_word = (level_q != '0);
    assign last_bit  = (cnt_q == CW'(WIDTH - 1));
    assign cnt_nxt   = cnt_q + CW'(1);
    assign head      = mem[rd_ptr_q];

    // Ready is derived only from registered level, so a same-cycle pop never frees a slot.
    assign bus.din_ready = reset & ~bus.flush & (level_q < LW'(DEPTH));
    assign push          = bus.din_valid & bus.din_ready;

    assign level_d = level_q + LW'(push) - LW'(pop);

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr_q] <= bus.din;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else if (bus.flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push)
                wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)
                rd_ptr_q <= rd_ptr_q + PW'(1);
            level_q <= level_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            word_q  <= '0;
            cnt_q   <= '0;
            bit_q   <= IDLE_BIT;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
        end
    end

    // Shifter FSM: a pop on the last-bit edge keeps SHIFT so the stream has no gap.
    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        pop     = 1'b0;

        if (bus.flush) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            bit_d   = IDLE_BIT;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    bit_d = IDLE_BIT;
                    if (have_word) begin
                        pop     = 1'b1;
                        state_d = ST_SHIFT;
                        word_d  = head;
                        cnt_d   = '0;
                        bit_d   = bit_at(head, '0);
                    end
                end
                ST_SHIFT: begin
                    if (!last_bit) begin
                        cnt_d = cnt_nxt;
                        bit_d = bit_at(word_q, cnt_nxt);
                    end else if (have_word) begin
                        pop    = 1'b1;
                        word_d = head;
                        cnt_d  = '0;
                        bit_d  = bit_at(head, '0);
                    end else begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                        bit_d   = IDLE_BIT;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    bit_d   = IDLE_BIT;
                end
            endcase
        end
    end

    assign bus.bit_out   = bit_q;
    assign bus.bit_valid = (state_q == ST_SHIFT);
    assign bus.busy      = (state_q == ST_SHIFT);
    assign bus.level     = level_q;
endmodule

// File: tb/tb_bit_stream_serializer.sv
// Directed bench for bit_stream_serializer: per-word bit order, latency, backpressure,
// flush and asynchronous reset, with a small 0110 detector model on the stream.
module tb_bit_stream_serializer;
    logic clk;
    logic reset;
    int   checks;
    int   errors;

    bit_stream_serializer_if bus ();
    bit_stream_serializer_if bus_l ();

    bit_stream_serializer #(.WIDTH(8), .DEPTH(4), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut (
        .clk(clk), .reset(reset), .bus(bus));

    bit_stream_serializer #(.WIDTH(8), .DEPTH(4), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) dut_l (
        .clk(clk), .reset(reset), .bus(bus_l));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       lsb;
        logic [7:0] word;
        logic [7:0] seq;   // expected bits in time order, seq[7] first
    } vec_t;
    vec_t vecs[6];

    // 0110 detector model fed from the MSB-first stream
    logic [3:0] hist;
    int         det_cnt;
    logic       det_clr;
    always @(posedge clk) begin
        if (det_clr) begin
            hist    <= 4'b0000;
            det_cnt <= 0;
        end else if (bus.bit_valid) begin
            hist <= {hist[2:0], bus.bit_out};
            if ({hist[2:0], bus.bit_out} == 4'b0110)
                det_cnt <= det_cnt + 1;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_in(input logic lsb, input logic [7:0] w, input logic v);
        if (lsb) begin
            bus_l.din       = w;
            bus_l.din_valid = v;
        end else begin
            bus.din       = w;
            bus.din_valid = v;
        end
    endtask

    function automatic logic rdy(input logic lsb);
        return lsb ? bus_l.din_ready : bus.din_ready;
    endfunction
    function automatic logic vld(input logic lsb);
        return lsb ? bus_l.bit_valid : bus.bit_valid;
    endfunction
    function automatic logic bo(input logic lsb);
        return lsb ? bus_l.bit_out : bus.bit_out;
    endfunction
    function automatic logic [2:0] lvl(input logic lsb);
        return lsb ? bus_l.level : bus.level;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One word into an idle, empty serializer; called 1 time unit after an edge.
    task automatic run_single(input logic lsb, input logic [7:0] w, input logic [7:0] seq,
                              input string tag);
        set_in(lsb, w, 1'b1);
        check({tag, " ready"}, 64'(rdy(lsb)), 64'd1);
        tick();
        set_in(lsb, 8'h00, 1'b0);
        check({tag, " nobypass_level"}, 64'(lvl(lsb)), 64'd1);
        check({tag, " nobypass_valid"}, 64'(vld(lsb)), 64'd0);
        tick();
        for (int i = 0; i < 8; i++) begin
            check($sformatf("%s valid%0d", tag, i), 64'(vld(lsb)), 64'd1);
            check($sformatf("%s bit%0d", tag, i), 64'(bo(lsb)), 64'(seq[7-i]));
            tick();
        end
        check({tag, " end_valid"}, 64'(vld(lsb)), 64'd0);
        check({tag, " idle_bit"}, 64'(bo(lsb)), 64'd0);
    endtask

    initial begin
        logic [15:0] seq16;
        logic [7:0]  fw [6];
        int          acc [6];
        int          idx, first, last, nv, cnt;
        logic        r;
        logic [47:0] got, exp48;

        checks = 0;
        errors = 0;
        det_clr = 1'b1;
        reset = 1'b0;
        bus.flush = 1'b0;   bus.din = '0;   bus.din_valid = 1'b0;
        bus_l.flush = 1'b0; bus_l.din = '0; bus_l.din_valid = 1'b0;

        vecs[0] = '{lsb: 1'b0, word: 8'hA5, seq: 8'hA5};
        vecs[1] = '{lsb: 1'b0, word: 8'h01, seq: 8'h01};
        vecs[2] = '{lsb: 1'b1, word: 8'h36, seq: 8'h6C};
        vecs[3] = '{lsb: 1'b1, word: 8'h01, seq: 8'h80};
        vecs[4] = '{lsb: 1'b1, word: 8'h0F, seq: 8'hF0};
        vecs[5] = '{lsb: 1'b1, word: 8'h80, seq: 8'h01};

        // reset state
        #12;
        check("rst din_ready", 64'(bus.din_ready), 64'd0);
        check("rst bit_valid", 64'(bus.bit_valid), 64'd0);
        check("rst busy", 64'(bus.busy), 64'd0);
        check("rst level", 64'(bus.level), 64'd0);
        check("rst bit_out", 64'(bus.bit_out), 64'd0);
        check("rst lsb din_ready", 64'(bus_l.din_ready), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        tick();
        det_clr = 1'b0;
        tick();

        // single 0x36 word, detector sees two overlapping 0110
        run_single(1'b0, 8'h36, 8'h36, "t1");
        check("t1 detector", 64'(det_cnt), 64'd2);

        for (int i = 0; i < 6; i++)
            run_single(vecs[i].lsb, vecs[i].word, vecs[i].seq, $sformatf("vec%0d", i));

        // back-to-back words, no gap
        seq16 = 16'h6696;
        set_in(1'b0, 8'h66, 1'b1);
        tick();
        set_in(1'b0, 8'h96, 1'b1);
        tick();
        set_in(1'b0, 8'h00, 1'b0);
        check("t2 level_pushpop", 64'(bus.level), 64'd1);
        for (int i = 0; i < 16; i++) begin
            check($sformatf("t2 valid%0d", i), 64'(bus.bit_valid), 64'd1);
            check($sformatf("t2 bit%0d", i), 64'(bus.bit_out), 64'(seq16[15-i]));
            tick();
        end
        check("t2 end_valid", 64'(bus.bit_valid), 64'd0);

        // full FIFO and backpressure with six queued words
        fw[0] = 8'h11; fw[1] = 8'h22; fw[2] = 8'h33;
        fw[3] = 8'h44; fw[4] = 8'h55; fw[5] = 8'hA7;
        exp48 = {fw[0], fw[1], fw[2], fw[3], fw[4], fw[5]};
        got = '0;
        idx = 0; first = -1; last = -1; nv = 0;
        for (int k = 0; k < 6; k++) acc[k] = -1;
        set_in(1'b0, fw[0], 1'b1);
        for (int cyc = 0; cyc < 60; cyc++) begin
            r = bus.din_ready;
            tick();
            if (bus.din_valid && r) begin
                acc[idx] = cyc;
                idx++;
                if (idx < 6) set_in(1'b0, fw[idx], 1'b1);
                else         set_in(1'b0, 8'h00, 1'b0);
            end
            if (bus.bit_valid) begin
                if (first < 0) first = cyc;
                last = cyc;
                if (nv < 48) got[47-nv] = bus.bit_out;
                nv++;
            end
            if (cyc == 4) begin
                check("t3 full_level", 64'(bus.level), 64'd4);
                check("t3 full_ready", 64'(bus.din_ready), 64'd0);
                check("t3 busy", 64'(bus.busy), 64'd1);
            end
            if (cyc == 8)
                check("t3 ready_at_pop", 64'(bus.din_ready), 64'd0);
        end
        set_in(1'b0, 8'h00, 1'b0);
        check("t3 fifth_accept", 64'(acc[4]), 64'd4);
        check("t3 sixth_accept", 64'(acc[5]), 64'd10);
        check("t3 first_valid", 64'(first), 64'd1);
        check("t3 last_valid", 64'(last), 64'd48);
        check("t3 valid_count", 64'(nv), 64'd48);
        check("t3 stream", 64'(got), 64'(exp48));
        check("t3 end_level", 64'(bus.level), 64'd0);

        // flush after three bits of 0xFF with 0x00 queued
        set_in(1'b0, 8'hFF, 1'b1);
        tick();
        set_in(1'b0, 8'h00, 1'b1);
        tick();
        set_in(1'b0, 8'h00, 1'b0);
        check("t5 bit0", 64'(bus.bit_out), 64'd1);
        tick();
        check("t5 bit1", 64'(bus.bit_out), 64'd1);
        tick();
        check("t5 bit2", 64'(bus.bit_out), 64'd1);
        check("t5 level_before", 64'(bus.level), 64'd1);
        bus.flush = 1'b1;
        set_in(1'b0, 8'h5A, 1'b1);
        #1;
        check("t5 ready_flush", 64'(bus.din_ready), 64'd0);
        tick();
        bus.flush = 1'b0;
        set_in(1'b0, 8'h00, 1'b0);
        check("t5 valid", 64'(bus.bit_valid), 64'd0);
        check("t5 level", 64'(bus.level), 64'd0);
        check("t5 bit_out", 64'(bus.bit_out), 64'd0);
        check("t5 busy", 64'(bus.busy), 64'd0);
        cnt = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (bus.bit_valid) cnt++;
        end
        check("t5 residual_bits", 64'(cnt), 64'd0);

        // asynchronous reset between edges, mid-word
        set_in(1'b0, 8'h36, 1'b1);
        tick();
        set_in(1'b0, 8'h00, 1'b0);
        tick();
        tick();
        tick();
        check("t6 midword_valid", 64'(bus.bit_valid), 64'd1);
        #3;
        reset = 1'b0;
        #1;
        check("t6 async_valid", 64'(bus.bit_valid), 64'd0);
        check("t6 async_busy", 64'(bus.busy), 64'd0);
        check("t6 async_level", 64'(bus.level), 64'd0);
        check("t6 async_bit_out", 64'(bus.bit_out), 64'd0);
        check("t6 async_ready", 64'(bus.din_ready), 64'd0);
        tick();
        @(negedge clk);
        reset = 1'b1;
        tick();
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus.bit_valid) cnt++;
        end
        check("t6 residual_bits", 64'(cnt), 64'd0);
        run_single(1'b0, 8'h36, 8'h36, "t6 after");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
